record_play_sequencer: RTL and testbench
========================================

RECORD_PLAY_SEQUENCER -- requirements
Module: record_play_sequencer

Interface
REQ-001 Parameter ADDR_W, default 6, note-memory address width (depth 2**ADDR_W).
REQ-002 Parameter DATA_W, default 32, note word width.
REQ-003 clk  in  1  system clock (50 MHz); one clock only.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 select  in  1  select key, active-high, already inverted from KEY.
REQ-006 back  in  1  back key, active-high, already inverted from KEY.
REQ-007 mode_play  in  1  mode switch sampled on select release: 0 = record, 1 = play.
REQ-008 tick  in  1  one-cycle tempo pulse from the clock divider.
REQ-009 note_in  in  DATA_W  encoded note to record.
REQ-010 ram_addr  out  ADDR_W  note-memory address; equals the internal address register.
REQ-011 ram_wdata  out  DATA_W  write data; equals note_in.
REQ-012 ram_wren  out  1  one-cycle write strobe.
REQ-013 ram_rdata  in  DATA_W  synchronous RAM output, one-cycle read latency.
REQ-014 note_out  out  DATA_W  registered playback note to the audio path.
REQ-015 note_valid  out  1  one-cycle pulse marking new note_out.
REQ-016 rec_len  out  ADDR_W+1  number of recorded notes, 0..2**ADDR_W.
REQ-017 state  out  3  current FSM state encoding, for LEDs/debug.

Function
REQ-018 A key action is the falling edge of select or back (press then release), detected with registered previous values.
REQ-019 States: IDLE, ARM_REC, RECORD, PLAY, DONE.
REQ-020 IDLE: select release with mode_play=0 -> ARM_REC, address cleared; with mode_play=1 and rec_len>0 -> PLAY, address cleared; with mode_play=1 and rec_len=0 -> stay IDLE.
REQ-021 ARM_REC: select release -> RECORD; back release -> IDLE; ticks ignored.
REQ-022 RECORD: on tick, ram_wren=1 for that cycle at the current address, address increments at the end of that cycle, and rec_len = address+1.
REQ-023 RECORD: when a tick writes the last address (2**ADDR_W-1) -> DONE and rec_len = 2**ADDR_W; the address never wraps while recording.
REQ-024 RECORD: select release -> DONE with rec_len kept; back release -> IDLE with rec_len cleared to 0.
REQ-025 PLAY: a tick in cycle T, with address A held in T, leaves ram_rdata valid in T+1; the block registers it into note_out, so note_out is updated and note_valid=1 in T+2; the address increments at the end of T.
REQ-026 PLAY: after the tick that reads address rec_len-1 -> DONE; the pending note_valid still fires.
REQ-027 PLAY: select or back release -> IDLE; an in-flight read still produces its note_valid.
REQ-028 DONE: any select or back release -> IDLE.
REQ-029 Same-cycle tick and key release: the tick's write or read is performed first, then the key transition is taken.
REQ-030 Same-cycle select and back release: back wins.
REQ-031 ram_wren is never asserted outside RECORD; note_valid is never asserted without a preceding PLAY read.

Reset
REQ-032 resetn low immediately forces state=IDLE, address=0, rec_len=0, note_out=0, note_valid=0, ram_wren=0 and clears the edge-detect registers.
REQ-033 Reset during RECORD or PLAY discards the recording: rec_len=0 after release.

Configuration
REQ-034 Macro PLAY_LOOP_EN defined: after reading address rec_len-1 in PLAY, the address returns to 0 and PLAY continues until a key release.
REQ-035 Macro PLAY_LOOP_EN undefined: REQ-026 applies (single pass, then DONE).

Structure
REQ-036 A shared package holds the state enumeration, the default ADDR_W and DATA_W constants, and the derived DEPTH = 2**ADDR_W.
REQ-037 One sub-module, key_release_det, provides the per-key falling-edge pulse; it is instantiated twice.

Verification
REQ-038 Record 3 notes: IDLE, mode_play=0, select release twice, 3 ticks with note_in=0x1, 0x40, 0x1000, then select release -> three ram_wren pulses at addresses 0, 1, 2; rec_len=3; state=DONE.
REQ-039 Play back: from IDLE, mode_play=1, select release, 3 ticks -> note_valid fires 2 cycles after each tick with note_out 0x1, 0x40, 0x1000, then DONE; with PLAY_LOOP_EN, a 4th tick yields 0x1 again.
REQ-040 Full memory: 64 ticks in RECORD -> last write at address 63, rec_len=64, DONE; a 65th tick gives no ram_wren.
REQ-041 Back during RECORD after 5 writes -> IDLE, rec_len=0; then play with mode_play=1 -> stays IDLE.
REQ-042 Same-cycle tick and select release in RECORD at address 7 -> the write at address 7 occurs, rec_len=8, DONE.
REQ-043 resetn low mid-PLAY -> next cycle all outputs 0, state=IDLE, and no note_valid afterwards.

Source files
------------

// File: rtl/record_play_sequencer_pkg.sv
// Shared types and default sizing for the record/play sequencer.
package record_play_sequencer_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM_REC = 3'd1,
        ST_RECORD  = 3'd2,
        ST_PLAY    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/record_play_sequencer_key_release_det.sv
// Key release detector: one-cycle pulse in the cycle a held key is let go.
module key_release_det
    import record_play_sequencer_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic key,
    output logic release_pulse
);

    logic key_prev_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_prev_reg <= 1'b0;
        end else begin
            key_prev_reg <= key;
        end
    end

    assign release_pulse = key_prev_reg & ~key;

endmodule

// File: rtl/record_play_sequencer.sv
// Record/play note sequencer driving an external synchronous note RAM.
// Define PLAY_LOOP_EN to make playback wrap to address 0 instead of stopping.
module record_play_sequencer
    import record_play_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              select,
    input  logic              back,
    input  logic              mode_play,
    input  logic              tick,
    input  logic [DATA_W-1:0] note_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] note_out,
    output logic              note_valid,
    output logic [ADDR_W:0]   rec_len,
    output logic [2:0]        state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic              sel_rel;
    logic              back_rel;
    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W:0]   rec_len_reg;
    logic              rd_pending_reg;
    logic [DATA_W-1:0] note_out_reg;
    logic              note_valid_reg;

    logic              rec_tick;
    logic              play_tick;
    logic              last_play;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W:0]   addr_plus_one;

    key_release_det u_sel_det (
        .clk          (clk),
        .resetn       (resetn),
        .key          (select),
        .release_pulse(sel_rel)
    );

    key_release_det u_back_det (
        .clk          (clk),
        .resetn       (resetn),
        .key          (back),
        .release_pulse(back_rel)
    );

    assign rec_tick      = (state_reg == ST_RECORD) && tick;
    assign play_tick     = (state_reg == ST_PLAY) && tick;
    assign addr_inc      = addr_reg + ADDR_W'(1);
    assign addr_plus_one = {1'b0, addr_reg} + (ADDR_W+1)'(1);
    assign last_play     = (addr_plus_one == rec_len_reg);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            rec_len_reg    <= '0;
            rd_pending_reg <= 1'b0;
            note_out_reg   <= '0;
            note_valid_reg <= 1'b0;
        end else begin
            // Read pipeline runs independently of state so an in-flight read always lands.
            rd_pending_reg <= play_tick;
            note_valid_reg <= rd_pending_reg;
            if (rd_pending_reg) begin
                note_out_reg <= ram_rdata;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (sel_rel && !back_rel) begin
                        if (!mode_play) begin
                            state_reg <= ST_ARM_REC;
                            addr_reg  <= '0;
                        end else if (rec_len_reg != '0) begin
                            state_reg <= ST_PLAY;
                            addr_reg  <= '0;
                        end
                    end
                end
                ST_ARM_REC: begin
                    if (back_rel) begin
                        state_reg <= ST_IDLE;
                    end else if (sel_rel) begin
                        state_reg <= ST_RECORD;
                    end
                end
                ST_RECORD: begin
                    if (tick) begin
                        rec_len_reg <= addr_plus_one;
                        if (addr_reg == LAST_ADDR) begin
                            state_reg <= ST_DONE;
                        end else begin
                            addr_reg <= addr_inc;
                        end
                    end
                    // Key transitions override the tick's state change; back discards the take.
                    if (back_rel) begin
                        state_reg   <= ST_IDLE;
                        rec_len_reg <= '0;
                    end else if (sel_rel) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (last_play) begin
`ifdef PLAY_LOOP_EN
                            addr_reg <= '0;
`else
                            state_reg <= ST_DONE;
`endif
                        end else begin
                            addr_reg <= addr_inc;
                        end
                    end
                    if (sel_rel || back_rel) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (sel_rel || back_rel) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_addr   = addr_reg;
    assign ram_wdata  = note_in;
    assign ram_wren   = rec_tick;
    assign note_out   = note_out_reg;
    assign note_valid = note_valid_reg;
    assign rec_len    = rec_len_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_record_play_sequencer.sv
// Self-checking bench: directed table, hand-written corner sequences and a random run against a note-level model.
module tb_record_play_sequencer;
    import record_play_sequencer_pkg::*;

    localparam int AW      = 6;
    localparam int DW      = 32;
    localparam int DEPTH_T = 64;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          select = 1'b0;
    logic          back = 1'b0;
    logic          mode_play = 1'b0;
    logic          tick = 1'b0;
    logic [DW-1:0] note_in = '0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wren;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] note_out;
    logic          note_valid;
    logic [AW:0]   rec_len;
    logic [2:0]    state;

    always #10 clk = ~clk;

    record_play_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .select    (select),
        .back      (back),
        .mode_play (mode_play),
        .tick      (tick),
        .note_in   (note_in),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wren  (ram_wren),
        .ram_rdata (ram_rdata),
        .note_out  (note_out),
        .note_valid(note_valid),
        .rec_len   (rec_len),
        .state     (state)
    );

    // Note RAM with one-cycle registered read
    logic [DW-1:0] ram [DEPTH_T];
    always @(posedge clk) begin
        if (ram_wren) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model: memory image, take counter, play index, note pipeline
    state_t        m_st;
    logic [DW-1:0] m_mem [DEPTH_T];
    int            m_cnt, m_play, m_len;
    logic          m_psel, m_pback;
    logic          m_pend_v, m_nv;
    logic [DW-1:0] m_pend_n, m_nout;
    logic          last_wren;
    logic [AW-1:0] last_addr;

    task automatic model_reset();
        m_st = ST_IDLE; m_cnt = 0; m_play = 0; m_len = 0;
        m_psel = 0; m_pback = 0; m_pend_v = 0; m_nv = 0; m_pend_n = '0; m_nout = '0;
    endtask

    task automatic cycle(input logic s, input logic b, input logic t, input logic m, input logic [DW-1:0] n);
        logic srel, brel;
        select = s; back = b; tick = t; mode_play = m; note_in = n;
        #1;
        last_wren = ram_wren;
        last_addr = ram_addr;
        check("wren", ram_wren, (m_st == ST_RECORD) && t);
        if (t && m_st == ST_RECORD) check("wr_addr", ram_addr, m_cnt);
        if (t && m_st == ST_PLAY)   check("rd_addr", ram_addr, m_play);
        srel = m_psel & ~s; brel = m_pback & ~b;
        m_psel = s; m_pback = b;
        m_nv = m_pend_v;
        if (m_pend_v) m_nout = m_pend_n;
        m_pend_v = 1'b0;
        case (m_st)
            ST_IDLE: if (srel && !brel) begin
                if (!m) begin m_st = ST_ARM_REC; m_cnt = 0; end
                else if (m_len > 0) begin m_st = ST_PLAY; m_play = 0; end
            end
            ST_ARM_REC: if (brel) m_st = ST_IDLE; else if (srel) m_st = ST_RECORD;
            ST_RECORD: begin
                if (t) begin
                    m_mem[m_cnt] = n;
                    m_len = m_cnt + 1;
                    if (m_len == DEPTH_T) m_st = ST_DONE; else m_cnt++;
                end
                if (brel) begin m_st = ST_IDLE; m_len = 0; end
                else if (srel) m_st = ST_DONE;
            end
            ST_PLAY: begin
                if (t) begin
                    m_pend_v = 1'b1;
                    m_pend_n = m_mem[m_play];
                    if (m_play == m_len - 1) begin
`ifdef PLAY_LOOP_EN
                        m_play = 0;
`else
                        m_st = ST_DONE;
`endif
                    end else m_play++;
                end
                if (srel || brel) m_st = ST_IDLE;
            end
            default: if (srel || brel) m_st = ST_IDLE;
        endcase
        @(negedge clk);
        check("state", state, m_st);
        check("rec_len", rec_len, m_len);
        check("note_valid", note_valid, m_nv);
        check("note_out", note_out, m_nout);
    endtask

    task automatic press(input logic is_back, input logic m);
        cycle(!is_back, is_back, 1'b0, m, '0);
        cycle(1'b0, 1'b0, 1'b0, m, '0);
    endtask

    task automatic do_reset();
        select = 0; back = 0; tick = 0;
        resetn = 1'b0;
        #1;
        check("rst_state", state, ST_IDLE);
        check("rst_valid", note_valid, 1'b0);
        check("rst_note", note_out, '0);
        check("rst_len", rec_len, '0);
        check("rst_addr", ram_addr, '0);
        check("rst_wren", ram_wren, 1'b0);
        model_reset();
        @(negedge clk);
        check("rst_hold_valid", note_valid, 1'b0);
        resetn = 1'b1;
    endtask

    typedef struct {
        logic s, b, t;
        logic [DW-1:0] n;
        logic exp_wren;
        logic [AW-1:0] exp_addr;
        state_t exp_st;
        int exp_len;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] exp_notes [3];
    int            wr_count;

    initial begin
        exp_notes[0] = 32'h1; exp_notes[1] = 32'h40; exp_notes[2] = 32'h1000;
        // Record three notes from reset, then return to IDLE
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 6'd0, ST_IDLE,    0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 6'd0, ST_ARM_REC, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h0,    1'b0, 6'd0, ST_ARM_REC, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 6'd0, ST_RECORD,  0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h1,    1'b1, 6'd0, ST_RECORD,  1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 6'd0, ST_RECORD,  1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h40,   1'b1, 6'd1, ST_RECORD,  2});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h1000, 1'b1, 6'd2, ST_RECORD,  3});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 6'd0, ST_RECORD,  3});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 6'd0, ST_DONE,    3});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 6'd0, ST_DONE,    3});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 6'd0, ST_IDLE,    3});

        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", state, ST_IDLE);
        check("reset_len", rec_len, '0);
        check("reset_valid", note_valid, 1'b0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            cycle(vecs[i].s, vecs[i].b, vecs[i].t, 1'b0, vecs[i].n);
            check("tbl_wren", last_wren, vecs[i].exp_wren);
            if (vecs[i].exp_wren) check("tbl_addr", last_addr, vecs[i].exp_addr);
            check("tbl_state", state, vecs[i].exp_st);
            check("tbl_len", rec_len, vecs[i].exp_len);
            $display("vec %0d: state=%0d rec_len=%0d wren=%0b", i, state, rec_len, last_wren);
        end

        // Playback of the three notes, two cycles of latency each
        press(1'b0, 1'b1);
        check("play_enter", state, ST_PLAY);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 1, 1, '0);
            check("play_early", note_valid, 1'b0);
            cycle(0, 0, 0, 1, '0);
            check("play_valid", note_valid, 1'b1);
            check("play_note", note_out, exp_notes[k]);
            cycle(0, 0, 0, 1, '0);
        end
`ifdef PLAY_LOOP_EN
        check("loop_state", state, ST_PLAY);
        cycle(0, 0, 1, 1, '0);
        cycle(0, 0, 0, 1, '0);
        check("loop_note", note_out, 32'h1);
        check("loop_valid", note_valid, 1'b1);
`else
        check("play_done", state, ST_DONE);
`endif
        press(1'b0, 1'b1);
        check("play_exit", state, ST_IDLE);
        $display("playback: state=%0d note_out=%0h", state, note_out);

        // Fill the whole memory
        press(1'b0, 1'b0); press(1'b0, 1'b0);
        wr_count = 0;
        for (int k = 0; k < DEPTH_T; k++) begin
            cycle(0, 0, 1, 0, $urandom);
            if (last_wren) wr_count++;
        end
        check("full_writes", wr_count, DEPTH_T);
        check("full_last_addr", last_addr, DEPTH_T - 1);
        check("full_state", state, ST_DONE);
        check("full_len", rec_len, DEPTH_T);
        cycle(0, 0, 1, 0, 32'hdead);
        check("full_no_wren", last_wren, 1'b0);
        press(1'b0, 1'b0);
        $display("full memory: rec_len=%0d", rec_len);

        // Tick and select release in the same cycle at address 7
        press(1'b0, 1'b0); press(1'b0, 1'b0);
        for (int k = 0; k < 7; k++) cycle(0, 0, 1, 0, 32'h100 + k);
        cycle(1, 0, 0, 0, '0);
        cycle(0, 0, 1, 0, 32'h777);
        check("same_wren", last_wren, 1'b1);
        check("same_addr", last_addr, 7);
        check("same_len", rec_len, 8);
        check("same_state", state, ST_DONE);
        press(1'b1, 1'b0);
        $display("tick+select: rec_len=%0d", rec_len);

        // Back during recording discards the take; play then refuses
        press(1'b0, 1'b0); press(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cycle(0, 0, 1, 0, 32'h500 + k);
        press(1'b1, 1'b0);
        check("back_state", state, ST_IDLE);
        check("back_len", rec_len, 0);
        press(1'b0, 1'b1);
        check("empty_play", state, ST_IDLE);
        $display("back in record: rec_len=%0d", rec_len);

        // Reset with a read in flight
        press(1'b0, 1'b0); press(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, 0, 32'h900 + k);
        press(1'b0, 1'b0); press(1'b0, 1'b0);
        press(1'b0, 1'b1);
        check("rst_play_enter", state, ST_PLAY);
        cycle(0, 0, 1, 1, '0);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 0, 0, '0);
            check("post_rst_valid", note_valid, 1'b0);
        end
        $display("reset mid-play: state=%0d", state);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            else cycle($urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
                       $urandom_range(0, 2) == 0, 1'($urandom), $urandom);
        end
        $display("random: done, rec_len=%0d", rec_len);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
